// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default operand width for the divider.
package div_pkg;
  localparam int DEF_N = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on (N+1)-bit magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N:0] rem_in,
  input  logic       bit_in,
  input  logic [N:0] dvs,
  output logic [N:0] rem_out,
  output logic       q
);
  logic [N+1:0] t;
  always_comb begin
    t = {rem_in, bit_in};
    q = t >= {1'b0, dvs};
    rem_out = q ? (N+1)'(t - {1'b0, dvs}) : t[N:0];
  end
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: N-cycle restoring signed divider; define DIVZERO_DETECT_EN for the 2-cycle divide-by-zero path.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz
);
  localparam int CW = $clog2(N);
  state_t state, nxt;
  logic [N:0] r, dm, r_nxt;
  logic [N-1:0] a;
  logic [CW-1:0] cnt;
  logic qb, sd, sv, dz, dz_q;
  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? -x : x;
  endfunction
`ifdef DIVZERO_DETECT_EN
  assign dz = divisor == '0;
`else
  assign dz = 1'b0;
`endif
  div_step #(.N(N)) u_step (
    .rem_in (r),
    .bit_in (a[N-1]),
    .dvs    (dm),
    .rem_out(r_nxt),
    .q      (qb)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? (dz ? FIX : RUN) : IDLE) :
          state == RUN  ? (cnt == '0 ? FIX : RUN) :
          state == FIX  ? DONE : IDLE;
    busy = state == RUN || state == FIX;
    done = state == DONE;
  end
  // a holds the dividend magnitude and fills with quotient bits as it shifts out
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      a <= '0;
      dm <= '0;
      sd <= 1'b0;
      sv <= 1'b0;
      dz_q <= 1'b0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      dbz <= 1'b0;
    end else if (state == IDLE && start) begin
      r <= '0;
      a <= mag(dividend);
      dm <= {1'b0, mag(divisor)};
      sd <= dividend[N-1];
      sv <= divisor[N-1];
      dz_q <= dz;
      cnt <= CW'(N - 1);
    end else if (state == RUN) begin
      r <= r_nxt;
      a <= {a[N-2:0], qb};
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      quotient <= dz_q ? '1 : (sd ^ sv ? -a : a);
      remainder <= dz_q ? (sd ? -a : a) : (sd ? -r[N-1:0] : r[N-1:0]);
      dbz <= dz_q;
    end
  end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: scoreboard-driven self-checking bench for seq_signed_divider.
module tb_seq_signed_divider;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst, start, busy, done, dbz;
  logic [N-1:0] dividend, divisor, quotient, remainder;
  int cyc = 0;
  int tests = 0, fails = 0, t_acc, lat;
  logic [N-1:0] oq, orr;
  logic odz, got;
  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  seq_signed_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t m;
    longint sa, sbv;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    if (b == '0) begin
`ifdef DIVZERO_DETECT_EN
      m.q = '1; m.r = a; m.dbz = 1'b1; m.lat = 2;
`else
      m.q = '0; m.r = '0; m.dbz = 1'b0; m.lat = N + 2;
`endif
    end else begin
      m.q = 32'(sa / sbv);
      m.r = 32'(sa % sbv);
      m.dbz = 1'b0;
      m.lat = N + 2;
    end
    return m;
  endfunction

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    t_acc = cyc;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic wait_done();
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    if (sb.size() > 0) e = sb.pop_front();
    if (got) begin
      oq = quotient; orr = remainder; odz = dbz; lat = cyc - t_acc;
    end else begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, dbz, quotient, remainder} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, need all 0", busy, done, dbz, quotient, remainder);
    end
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_priority: busy=%b need 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] as[6] = '{32'd100, -32'd100, 32'd7, 32'd9, -32'd7, 32'd123456789};
    logic [N-1:0] bs[6] = '{32'd7, 32'd7, -32'd100, 32'd3, -32'd7, -32'd1000};
    logic [N-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        a = as[i]; b = bs[i];
      end else begin
        a = $urandom;
        b = (i % 2 == 1) ? $urandom : -32'($urandom_range(1, 50));
        if (b == '0) b = 32'd1;
      end
      launch(a, b);
      wait_done();
      if (got) begin
        tests++;
        if (oq !== e.q || orr !== e.r) begin
          fails++;
          $display("FAIL basic_%0d: %h/%h got q=%h r=%h need q=%h r=%h", i, a, b, oq, orr, e.q, e.r);
        end
        tests++;
        if (lat !== e.lat || odz !== 1'b0) begin
          fails++;
          $display("FAIL basic_lat_%0d: latency=%0d dbz=%b need %0d dbz=0", i, lat, odz, e.lat);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b0 || quotient !== oq || remainder !== orr) begin
          fails++;
          $display("FAIL basic_hold_%0d: done=%b q=%h r=%h need done=0 q=%h r=%h", i, done, quotient, remainder, oq, orr);
        end
      end
    end
  endtask

  task automatic test_overflow();
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    if (got) begin
      tests++;
      if (oq !== 32'h8000_0000 || orr !== 32'h0 || odz !== 1'b0) begin
        fails++;
        $display("FAIL overflow: q=%h r=%h dbz=%b need q=80000000 r=0 dbz=0", oq, orr, odz);
      end
    end
  endtask

  task automatic test_divzero();
    launch(32'd5, 32'd0);
    wait_done();
    if (got) begin
      tests++;
`ifdef DIVZERO_DETECT_EN
      if (odz !== 1'b1 || oq !== 32'hFFFF_FFFF || orr !== 32'd5 || lat !== 2) begin
        fails++;
        $display("FAIL divzero: dbz=%b q=%h r=%h lat=%0d need dbz=1 q=ffffffff r=5 lat=2", odz, oq, orr, lat);
      end
`else
      if (odz !== 1'b0 || lat !== N + 2) begin
        fails++;
        $display("FAIL divzero: dbz=%b lat=%0d need dbz=0 lat=%0d", odz, lat, N + 2);
      end
`endif
    end
    launch(-32'd20, 32'd6);
    wait_done();
    if (got) begin
      tests++;
      if (odz !== 1'b0 || oq !== -32'd3 || orr !== -32'd2) begin
        fails++;
        $display("FAIL after_divzero: dbz=%b q=%h r=%h need dbz=0 q=fffffffd r=fffffffe", odz, oq, orr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h need all 0", busy, done, quotient, remainder);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_nodone: saw %0d done cycles need 0", seen);
    end
    launch(32'd9, 32'd3);
    wait_done();
    if (got) begin
      tests++;
      if (oq !== 32'd3 || orr !== 32'd0) begin
        fails++;
        $display("FAIL reset_mid_next: q=%h r=%h need q=3 r=0", oq, orr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    launch(32'd1000, -32'd33);
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy: busy=%b need 1", busy);
    end
    dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    if (got) begin
      tests++;
      if (oq !== -32'd30 || orr !== 32'd10 || lat !== N + 2) begin
        fails++;
        $display("FAIL b2b_first: q=%h r=%h lat=%0d need q=ffffffe2 r=a lat=%0d", oq, orr, lat, N + 2);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ignored: extra done cycles=%0d busy=%b need 0 and 0", seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_divzero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
